muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MULT, MULTU, DIV and DIVU in the multi-cycle CPU.
- Captures Rs/Rt, runs a 32-step shift-add multiply or restoring divide on magnitudes, then applies sign correction.
- Delivers write data and write enables to the hi and lo hilo registers.
- The main controller holds its state while busy is high and resumes on done.

Parameters:
- WIDTH, 32, operand width; only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  32  Rs value (multiplicand / dividend)
- b  input  32  Rt value (multiplier / divisor)
- busy  output  1  high in PREP, ITER, FIX, DONE
- done  output  1  one-cycle pulse; result valid
- hi_wdata  output  32  data for hi_reg (product[63:32] / remainder)
- lo_wdata  output  32  data for lo_reg (product[31:0] / quotient)
- hi_ena  output  1  equals done
- lo_ena  output  1  equals done
- div_zero  output  1  pulses with done when a DIV/DIVU had b==0

Behaviour:
- Reset: state IDLE, iteration counter 0, busy 0, done 0, hi_ena 0, lo_ena 0, div_zero 0, hi_wdata 0, lo_wdata 0.
- FSM: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: when start=1 at an edge, latch op, a and b; next state PREP. start=0 stays in IDLE.
- PREP (1 cycle):
  - Compute magnitudes: negate a or b if the op is signed and the MSB is 1.
  - Record the result sign: product/quotient sign = a[31]^b[31]; remainder sign = a[31]; both 0 for unsigned ops.
  - Clear the 64-bit accumulator and set counter = 0.
- ITER (exactly 32 cycles, counter 0..31):
  - Multiply: if multiplier LSB=1, add the multiplicand magnitude into the upper 33 bits; then shift the 64-bit accumulator right by 1.
  - Divide (restoring): shift {rem,quo} left by 1; trial-subtract the divisor from rem; if non-negative, keep it and set quo LSB=1.
  - At counter 31 go to FIX.
- FIX (1 cycle):
  - Negate the 64-bit product if its sign is set.
  - Negate the quotient and remainder per their own signs.
  - Load hi_wdata and lo_wdata.
- DONE (1 cycle): done=1, hi_ena=1, lo_ena=1, div_zero per capture; next IDLE.
- Latency: start sampled at edge E; done is high in the cycle after edge E+34. Total 35 cycles IDLE-to-IDLE, fixed for every op and operand.
- hi_wdata and lo_wdata hold their value after DONE until the next FIX.
- start while busy=1 (including in the DONE cycle) is ignored. a, b and op changes after capture are ignored.
- Divide by zero (b==0, DIV or DIVU): full latency. Result is hi_wdata=a (unmodified), lo_wdata=32'hFFFFFFFF, div_zero=1 in DONE.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo_wdata=32'h80000000, hi_wdata=0, no flag.
- Arithmetic is modulo 2^32 per half; no overflow indication for any multiply.
- Reset during any state:
  - Return to IDLE next edge with all outputs at reset values.
  - No hi_ena/lo_ena pulse for the aborted op.
  - rst has priority over start on the same edge.

Test Plan:
- MULT a=32'hFFFFFFFD (-3), b=7 -> done after 35-cycle window; hi_wdata=FFFFFFFF, lo_wdata=FFFFFFEB; hi_ena=lo_ena=1 for exactly one cycle.
- MULTU a=b=FFFFFFFF -> hi_wdata=FFFFFFFE, lo_wdata=00000001. Then MULTU 0*12345678 -> hi_wdata=lo_wdata=0.
- DIV a=FFFFFFF9 (-7), b=2 -> lo_wdata=FFFFFFFD, hi_wdata=FFFFFFFF.
- DIVU a=100, b=7 -> lo_wdata=0000000E, hi_wdata=00000002.
- DIV a=80000000, b=FFFFFFFF -> lo_wdata=80000000, hi_wdata=0, div_zero=0.
- DIVU a=1234, b=0 -> lo_wdata=FFFFFFFF, hi_wdata=1234, div_zero=1 with done.
- start pulsed again at cycles 5 and 34 of a running MULT -> both ignored; exactly one done.
- Changing a and b during ITER -> result unaffected.
- rst asserted at cycle 10 of a DIV -> busy=0 next cycle; no done/ena pulse; hi_wdata=lo_wdata=0.
- A new op started immediately after reset -> completes with correct result.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle between the main CPU controller (master)
// and the multi-cycle multiply/divide sequencer (slave).
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;
  logic             hi_ena;
  logic             lo_ena;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi_wdata, lo_wdata, hi_ena, lo_ena, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi_wdata, lo_wdata, hi_ena, lo_ena, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: 32-step shift-add multiply or
// restoring divide on magnitudes, sign fix-up, then a one-cycle hi/lo write.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   mag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               psign_q, rsign_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_div, is_signed, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    last_iter = (cnt_q == CW'(WIDTH - 1));

    mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Trial subtraction on the shifted 33-bit remainder; bit WIDTH is the borrow.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    trial    = rem_sh - {1'b0, mag_q};
    div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    prod_neg = -acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.hi_ena   = 1'b0;
    bus.lo_ena   = 1'b0;
    bus.div_zero = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = S_PREP;
      end
      S_PREP: state_d = S_ITER;
      S_ITER: if (last_iter) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        bus.done     = 1'b1;
        bus.hi_ena   = 1'b1;
        bus.lo_ena   = 1'b1;
        bus.div_zero = dz_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      psign_q <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
          end
        end
        S_PREP: begin
          psign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rsign_q <= is_signed & a_q[WIDTH-1];
          dz_q    <= is_div && (b_q == '0);
          // Upper half cleared; lower half seeded with the multiplier or dividend.
          mag_q   <= is_div ? mag_b : mag_a;
          acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          cnt_q   <= '0;
        end
        S_ITER: begin
          acc_q <= is_div ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIX: begin
          if (dz_q) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else if (is_div) begin
            lo_q <= psign_q ? -quo : quo;
            hi_q <= rsign_q ? -rem : rem;
          end else begin
            {hi_q, lo_q} <= psign_q ? prod_neg : acc_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_wdata = hi_q;
  assign bus.lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, ignored starts,
// operand changes during iteration, divide-by-zero and reset abort.
module tb_muldiv_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called aligned to a falling edge; start is sampled on the next rising edge.
  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int p1, input int p2, input bit scramble);
    int          done_at;
    int          done_cnt;
    logic [31:0] hi_s, lo_s;
    logic        hena_s, lena_s, dz_s;
    logic        busy_first, busy_after;
    done_at  = 0;
    done_cnt = 0;
    hi_s = 'x; lo_s = 'x; hena_s = 'x; lena_s = 'x; dz_s = 'x;
    busy_first = 'x; busy_after = 'x;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (n == 1)  busy_first = bus.busy;
      if (n == 36) busy_after = bus.busy;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = n;
          hi_s    = bus.hi_wdata;
          lo_s    = bus.lo_wdata;
          hena_s  = bus.hi_ena;
          lena_s  = bus.lo_ena;
          dz_s    = bus.div_zero;
        end
      end
      bus.start = (n == p1) || (n == p2);
      if (scramble && n >= 2 && n <= 34) begin
        bus.a  = $urandom;
        bus.b  = $urandom;
        bus.op = 2'($urandom_range(0, 3));
      end
    end
    bus.start = 1'b0;
    check({tag, ".busy_prep"},  32'(busy_first), 32'd1);
    check({tag, ".done_cycle"}, 32'(done_at),    32'd35);
    check({tag, ".done_count"}, 32'(done_cnt),   32'd1);
    check({tag, ".hi_ena"},     32'(hena_s),     32'd1);
    check({tag, ".lo_ena"},     32'(lena_s),     32'd1);
    check({tag, ".div_zero"},   32'(dz_s),       32'(edz));
    check({tag, ".hi"},         hi_s,            ehi);
    check({tag, ".lo"},         lo_s,            elo);
    check({tag, ".busy_after"}, 32'(busy_after), 32'd0);
    check({tag, ".hi_hold"},    bus.hi_wdata,    ehi);
    check({tag, ".lo_hold"},    bus.lo_wdata,    elo);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst.busy",     32'(bus.busy),     32'd0);
    check("rst.done",     32'(bus.done),     32'd0);
    check("rst.hi_ena",   32'(bus.hi_ena),   32'd0);
    check("rst.lo_ena",   32'(bus.lo_ena),   32'd0);
    check("rst.div_zero", 32'(bus.div_zero), 32'd0);
    check("rst.hi",       bus.hi_wdata,      32'h0);
    check("rst.lo",       bus.lo_wdata,      32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mult_m3x7",    2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 5, 34, 1'b0);
    do_op("multu_max",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0,  1'b0);
    do_op("multu_zero",   2'b01, 32'h0,        32'h12345678, 32'h0,        32'h0,        1'b0, 0, 0,  1'b0);
    do_op("div_m7by2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0,  1'b0);
    do_op("divu_100by7",  2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 0, 0,  1'b0);
    do_op("div_minby_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 0, 0,  1'b0);
    do_op("divu_by0",     2'b11, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 0, 0,  1'b0);
    do_op("div_by0_neg",  2'b10, 32'hFFFFFF00, 32'h0,        32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 0, 0,  1'b0);
    do_op("divu_scram",   2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 35, 0, 1'b1);
    do_op("mult_scram",   2'b00, 32'd6,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 0, 0,  1'b1);

    // Abort a DIV partway through the iterations.
    bus.op    = 2'b10;
    bus.a     = 32'hFFFFFFF9;
    bus.b     = 32'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy",     32'(bus.busy),     32'd0);
    check("abort.done",     32'(bus.done),     32'd0);
    check("abort.hi_ena",   32'(bus.hi_ena),   32'd0);
    check("abort.lo_ena",   32'(bus.lo_ena),   32'd0);
    check("abort.div_zero", 32'(bus.div_zero), 32'd0);
    check("abort.hi",       bus.hi_wdata,      32'h0);
    check("abort.lo",       bus.lo_wdata,      32'h0);
    rst = 1'b0;

    do_op("post_rst_mult", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 1'b0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
